// File: rtl/cat_vec_pkg.sv
// Shared state type and default geometry for the concatenated-vector reader.
package cat_vec_pkg;

    typedef enum logic [1:0] {StIdle, StPull, StDrain} state_e;

    localparam int unsigned DefNBits       = 16;
    localparam int unsigned DefVecElements = 8;
    localparam int unsigned DefElementsIn  = 2;
    localparam int unsigned DefElementsOut = 4;

    localparam int unsigned Cap         = DefElementsIn + DefElementsOut;
    localparam int unsigned PullsPerVec = DefVecElements / DefElementsIn;
    localparam int unsigned BeatsPerVec = DefVecElements / DefElementsOut;
    localparam int unsigned FillW       = $clog2(Cap + 1);

endpackage

// File: rtl/cat_vec_stage_buf.sv
// Staging buffer: appends ElementsIn-wide chunks, pops ElementsOut-wide beats from element 0.
module cat_vec_stage_buf #(
    parameter int unsigned NBits       = 16,
    parameter int unsigned ElementsIn  = 2,
    parameter int unsigned ElementsOut = 4,
    localparam int unsigned BufCap     = ElementsIn + ElementsOut,
    localparam int unsigned FillBits   = $clog2(BufCap + 1)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         flush,
    input  logic                         push,
    input  logic [ElementsIn*NBits-1:0]  push_data,
    input  logic                         pop,
    output logic [FillBits-1:0]          fill,
    output logic [ElementsOut*NBits-1:0] data
);

    logic [BufCap*NBits-1:0] mem_q, mem_d;
    logic [FillBits-1:0]     fill_q, fill_d, base;

    // Slots at and above fill are always zero, so a push can simply be OR-ed in.
    always_comb begin
        mem_d = mem_q;
        base  = fill_q;
        if (pop) begin
            mem_d = mem_q >> (ElementsOut * NBits);
            base  = fill_q - FillBits'(ElementsOut);
        end
        if (push) begin
            mem_d = mem_d | ({{(ElementsOut*NBits){1'b0}}, push_data} << (int'(base) * NBits));
        end
        fill_d = base + (push ? FillBits'(ElementsIn) : '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            mem_q  <= '0;
            fill_q <= '0;
        end else begin
            mem_q  <= mem_d;
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;
    assign data = mem_q[ElementsOut*NBits-1:0];

endmodule

// File: rtl/cat_vec_reader.sv
// Pulls one concatenated vector per src_valid episode and re-emits it as ElementsOut-wide beats.
module cat_vec_reader
    import cat_vec_pkg::*;
#(
    parameter int unsigned NBits       = DefNBits,
    parameter int unsigned VecElements = DefVecElements,
    parameter int unsigned ElementsIn  = DefElementsIn,
    parameter int unsigned ElementsOut = DefElementsOut
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         src_valid,
    output logic                         src_rd_en,
    input  logic [ElementsIn*NBits-1:0]  src_data,
    output logic [ElementsOut*NBits-1:0] m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic                         busy,
    output logic                         err
);

    localparam int unsigned BufCap   = ElementsIn + ElementsOut;
    localparam int unsigned NumPulls = VecElements / ElementsIn;
    localparam int unsigned NumBeats = VecElements / ElementsOut;
    localparam int unsigned FillBits = $clog2(BufCap + 1);
    localparam int unsigned PullW    = $clog2(NumPulls + 1);
    localparam int unsigned BeatW    = $clog2(NumBeats + 1);

    state_e              state_q, state_d;
    logic [PullW-1:0]    pull_cnt_q, pull_cnt_d;
    logic [BeatW-1:0]    out_cnt_q, out_cnt_d;
    logic                armed_q, armed_d;
    logic                err_q, err_d;
    logic [FillBits-1:0] fill;
    logic                pop, flush, room;

    cat_vec_stage_buf #(
        .NBits      (NBits),
        .ElementsIn (ElementsIn),
        .ElementsOut(ElementsOut)
    ) u_stage_buf (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush    (flush),
        .push     (src_rd_en),
        .push_data(src_data),
        .pop      (pop),
        .fill     (fill),
        .data     (m_data)
    );

    assign m_valid = (state_q != StIdle) && (int'(fill) >= int'(ElementsOut));
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && (out_cnt_q == BeatW'(NumBeats - 1));
    assign busy    = (state_q != StIdle);
    assign err     = err_q;
    // A same-cycle pop frees a beat's worth of slots before the new chunk lands.
    assign room    = (int'(fill) - (pop ? int'(ElementsOut) : 0) + int'(ElementsIn))
                     <= int'(BufCap);

    always_comb begin
        state_d    = state_q;
        pull_cnt_d = pull_cnt_q;
        out_cnt_d  = pop ? out_cnt_q + BeatW'(1) : out_cnt_q;
        armed_d    = armed_q;
        err_d      = err_q;
        flush      = 1'b0;
        src_rd_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!src_valid) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d    = StPull;
                    pull_cnt_d = '0;
                    out_cnt_d  = '0;
                    armed_d    = 1'b0;
                end
            end
            StPull: begin
                if (!src_valid) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = StIdle;
                end else if (room) begin
                    src_rd_en  = 1'b1;
                    pull_cnt_d = pull_cnt_q + PullW'(1);
                    if (pull_cnt_q == PullW'(NumPulls - 1)) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && (out_cnt_q == BeatW'(NumBeats - 1))) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            pull_cnt_q <= '0;
            out_cnt_q  <= '0;
            armed_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pull_cnt_q <= pull_cnt_d;
            out_cnt_q  <= out_cnt_d;
            armed_q    <= armed_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_cat_vec_reader.sv
// Bench for cat_vec_reader: default 2-in/4-out instance plus a 4-in/2-out instance.
module tb_cat_vec_reader;

    localparam int NB = 16;
    localparam int VE = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: defaults (ElementsIn=2, ElementsOut=4)
    logic          a_valid, a_rd, a_mvalid, a_mready, a_last, a_busy, a_err;
    logic [2*NB-1:0] a_sdata;
    logic [4*NB-1:0] a_mdata;
    // Instance B: ElementsIn=4, ElementsOut=2
    logic          b_valid, b_rd, b_mvalid, b_mready, b_last, b_busy, b_err;
    logic [4*NB-1:0] b_sdata;
    logic [2*NB-1:0] b_mdata;

    logic [NB-1:0] vec_a [VE];
    logic [NB-1:0] vec_b [VE];
    int rd_a = 0, rd_b = 0, base_a = 0, base_b = 0;
    int bi_a = 0, bi_b = 0;

    cat_vec_reader dut_a (
        .clk_in(clk), .rst_in(rst), .src_valid(a_valid), .src_rd_en(a_rd),
        .src_data(a_sdata), .m_data(a_mdata), .m_valid(a_mvalid), .m_ready(a_mready),
        .m_last(a_last), .busy(a_busy), .err(a_err)
    );

    cat_vec_reader #(.NBits(16), .VecElements(8), .ElementsIn(4), .ElementsOut(2)) dut_b (
        .clk_in(clk), .rst_in(rst), .src_valid(b_valid), .src_rd_en(b_rd),
        .src_data(b_sdata), .m_data(b_mdata), .m_valid(b_mvalid), .m_ready(b_mready),
        .m_last(b_last), .busy(b_busy), .err(b_err)
    );

    // Upstream model: the k-th read of a vector returns elements k*ElementsIn onward.
    always @(posedge clk) begin
        if (a_rd === 1'b1) rd_a <= rd_a + 1;
        if (b_rd === 1'b1) rd_b <= rd_b + 1;
    end

    always_comb begin
        a_sdata = '0;
        b_sdata = '0;
        for (int i = 0; i < 2; i++) a_sdata[i*NB +: NB] = vec_a[((rd_a - base_a) * 2 + i) % VE];
        for (int i = 0; i < 4; i++) b_sdata[i*NB +: NB] = vec_b[((rd_b - base_b) * 4 + i) % VE];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted beat must be the next ElementsOut elements of the vector.
    task automatic chk_pops();
        logic [63:0] e;
        if (a_mvalid === 1'b1 && a_mready === 1'b1) begin
            e = '0;
            for (int i = 0; i < 4; i++) e[i*NB +: NB] = vec_a[(bi_a * 4 + i) % VE];
            check($sformatf("a_beat%0d_data", bi_a), 64'(a_mdata), e);
            check($sformatf("a_beat%0d_last", bi_a), 64'(a_last), 64'(bi_a == 1));
            bi_a++;
        end
        if (b_mvalid === 1'b1 && b_mready === 1'b1) begin
            e = '0;
            for (int i = 0; i < 2; i++) e[i*NB +: NB] = vec_b[(bi_b * 2 + i) % VE];
            check($sformatf("b_beat%0d_data", bi_b), 64'(b_mdata), e);
            check($sformatf("b_beat%0d_last", bi_b), 64'(b_last), 64'(bi_b == 3));
            bi_b++;
        end
    endtask

    task automatic next();
        chk_pops();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        #1;
        next();
    endtask

    task automatic new_vec_a();
        for (int i = 0; i < VE; i++) vec_a[i] = NB'($urandom);
        base_a = rd_a;
        bi_a   = 0;
    endtask

    task automatic new_vec_b();
        for (int i = 0; i < VE; i++) vec_b[i] = NB'($urandom);
        base_b = rd_b;
        bi_b   = 0;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_mready = 1'b0;
        b_valid = 1'b0; b_mready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        #1;
        check("rst_busy", 64'(a_busy), 0);
        check("rst_err", 64'(a_err), 0);
        check("rst_mvalid", 64'(a_mvalid), 0);
        check("rst_rd", 64'(a_rd), 0);
        check("rst_mdata", 64'(a_mdata), 0);
        check("rst_last", 64'(a_last), 0);
        rst = 1'b0;
        next();

        // Single vector with m_ready held high, then src_valid kept high afterwards.
        new_vec_a();
        a_valid = 1'b1; a_mready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("t1_rd_c%0d", c), 64'(a_rd), 64'(c >= 1 && c <= 4));
            check($sformatf("t1_mvalid_c%0d", c), 64'(a_mvalid), 64'(c == 3 || c == 5));
            check($sformatf("t1_last_c%0d", c), 64'(a_last), 64'(c == 5));
            check($sformatf("t1_busy_c%0d", c), 64'(a_busy), 64'(c >= 1 && c <= 5));
            next();
        end
        check("t1_beats", 64'(bi_a), 2);

        // Backpressure from cycle 3, released in cycle 9.
        a_valid = 1'b0;
        tick();
        new_vec_a();
        a_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            a_mready = (c < 3 || c >= 9);
            #1;
            if (c >= 4 && c <= 8) begin
                check($sformatf("t2_rd_blocked_c%0d", c), 64'(a_rd), 0);
                check($sformatf("t2_hold_valid_c%0d", c), 64'(a_mvalid), 1);
                check($sformatf("t2_hold_data_c%0d", c), 64'(a_mdata),
                      64'({vec_a[3], vec_a[2], vec_a[1], vec_a[0]}));
            end
            if (c == 3 || c == 9) check($sformatf("t2_rd_c%0d", c), 64'(a_rd), 1);
            next();
        end
        check("t2_beats", 64'(bi_a), 2);
        check("t2_idle", 64'(a_busy), 0);

        // Abort: src_valid dropped in cycle 2.
        a_valid = 1'b0;
        tick();
        new_vec_a();
        a_valid = 1'b1;
        tick();
        tick();
        a_valid = 1'b0;
        #1;
        check("t3_abort_rd", 64'(a_rd), 0);
        next();
        #1;
        check("t3_err", 64'(a_err), 1);
        check("t3_mvalid", 64'(a_mvalid), 0);
        check("t3_busy", 64'(a_busy), 0);
        next();
        new_vec_a();
        a_valid = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        check("t3_recover_beats", 64'(bi_a), 2);
        check("t3_err_sticky", 64'(a_err), 1);

        // Reset while a beat is held.
        a_valid = 1'b0;
        tick();
        new_vec_a();
        a_valid = 1'b1; a_mready = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        #1;
        check("t4_held_valid", 64'(a_mvalid), 1);
        rst = 1'b1; a_valid = 1'b0;
        next();
        rst = 1'b0;
        #1;
        check("t4_busy", 64'(a_busy), 0);
        check("t4_err", 64'(a_err), 0);
        check("t4_mvalid", 64'(a_mvalid), 0);
        check("t4_rd", 64'(a_rd), 0);
        check("t4_mdata", 64'(a_mdata), 0);
        check("t4_last", 64'(a_last), 0);
        next();
        new_vec_a();
        a_valid = 1'b1; a_mready = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        check("t4_fresh_beats", 64'(bi_a), 2);

        // Random m_ready on both geometries.
        for (int v = 0; v < 3; v++) begin
            a_valid = 1'b0; b_valid = 1'b0;
            tick();
            new_vec_a();
            new_vec_b();
            a_valid = 1'b1; b_valid = 1'b1;
            for (int c = 0; c < 40; c++) begin
                a_mready = ($urandom_range(3) != 0);
                b_mready = ($urandom_range(3) != 0);
                tick();
            end
            check($sformatf("rnd%0d_a_beats", v), 64'(bi_a), 2);
            check($sformatf("rnd%0d_b_beats", v), 64'(bi_b), 4);
            check($sformatf("rnd%0d_a_idle", v), 64'(a_busy), 0);
            check($sformatf("rnd%0d_b_idle", v), 64'(b_busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
